tis_grid_loader: RTL and testbench
==================================

Name: tis_grid_loader

Overview:
Configuration and run controller for a grid of TIS cores. It accepts a word stream over a valid/ready handshake, decodes per-core program frames, and writes instruction words and program lengths into each core's program store. It holds the cores in reset while loading. It then sequences execution: free-run, single-step or halt. Its clock-enable and reset outputs fan out to every core.

Parameters:
NCORES, 12, number of cores addressed; core index must be < NCORES
PROG_DEPTH, 15, maximum instructions per core
CNT_W, 32, width of executed-cycle counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
in_valid  in  1  stream word valid
in_data  in  16  stream word
in_ready  out  1  stream word accepted when in_valid & in_ready
load_req  in  1  abort execution, re-enter loading
start_run  in  1  begin free-running execution
step  in  1  execute exactly one core cycle
halt  in  1  stop free-running execution
core_rst  out  1  reset to all cores
clk_en  out  1  per-cycle execute enable to all cores
prog_we  out  1  program word write strobe
prog_core  out  4  target core index
prog_addr  out  4  instruction slot
prog_wdata  out  16  instruction word
plen_we  out  1  program-length write strobe
plen_wdata  out  4  program length
running  out  1  high in RUN
err  out  1  sticky frame error
cycle_cnt  out  CNT_W  count of cycles with clk_en=1

Behaviour:
- Reset is synchronous. After rst: state HDR, core_rst=1, clk_en=0, in_ready=1, all strobes 0, err=0, cycle_cnt=0, running=0.
- Stream format: header word has bit15=1. bit14=1 means END; otherwise [11:8]=core index and [3:0]=length L. Bits [13:12] and [7:4] are ignored. Body words are taken verbatim; bit15 has no meaning in BODY.
- States: HDR, BODY, FILL, DRAIN, READY, RUN.
- HDR, valid header with core<NCORES and 1<=L<=PROG_DEPTH: plen_we=1 with plen_wdata=L and prog_core=core on the next cycle. Latch core, set addr=0, go to BODY.
- HDR, header with L=0: go to FILL. FILL lasts one cycle with in_ready=0. In FILL, plen_we=1 with plen_wdata=1, and prog_we=1 with addr 0 and data 16'h7FFF (NOP). Then return to HDR.
- BODY: each accepted word produces prog_we=1 the following cycle, at the current addr. addr increments after each word. After word L is accepted, go to HDR.
- HDR, END header: go to READY. core_rst drops to 0 on the cycle READY is entered.
- Errors go to DRAIN and set err=1. Error cases:
  - in HDR, a word with bit15=0;
  - in HDR, core>=NCORES;
  - in HDR, L>PROG_DEPTH.
- DRAIN: accept and discard every word until an END header, then go to READY with err still 1. No strobes are issued in DRAIN.
- core_rst=1 in HDR/BODY/FILL/DRAIN and 0 in READY/RUN. in_ready=1 only in HDR/BODY/DRAIN.
- READY: clk_en=0.
  - start_run with err=0: go to RUN.
  - step with err=0: clk_en=1 for exactly the next cycle, then 0. A held step yields one pulse per rising edge of step.
  - start_run and step are ignored while err=1.
- RUN: clk_en=1 every cycle. halt: clk_en=0 from the next cycle, go to READY. step and start_run are ignored in RUN.
- Priority when inputs coincide: rst > load_req > halt > start_run > step.
- load_req in any state other than HDR/BODY/FILL/DRAIN: go to HDR next cycle. This asserts core_rst, forces clk_en=0 and clears err and cycle_cnt. load_req during loading is ignored.
- cycle_cnt increments on each cycle where clk_en=1 and saturates at all-ones.
- Cores not named in a load keep their previous program and length.
- All outputs are registered. Latency from handshake to strobe is exactly 1 cycle.

Decomposition:
- Package tis_pkg holds:
  - header bit positions (HDR_BIT=15, END_BIT=14, core field [11:8], len field [3:0]);
  - NOP_WORD=16'h7FFF;
  - the state enum {HDR, BODY, FILL, DRAIN, READY, RUN}.
- Single module; no sub-module. The edge detector for step and the saturating counter stay inline.

Test Plan:
- Load core 2 with L=3, words 16'h0802/16'h4801/16'h7FFF, then END -> plen_we with core 2 and len 3; three prog_we at addr 0,1,2 with matching data, each 1 cycle after its handshake; core_rst falls after END.
- Header with core 5, L=0, then END -> FILL cycle with in_ready=0; plen_wdata=1; prog_we at addr 0 with data 16'h7FFF.
- Header with core 13 (NCORES=12), body words, then END -> err=1, no strobes, READY. start_run then has no effect (running=0, clk_en=0).
- From READY, pulse step 3 times (held 2 cycles each) -> exactly 3 single-cycle clk_en pulses; cycle_cnt=3.
- start_run, wait 10 cycles, assert halt and start_run together -> halt wins; cycle_cnt=10; state READY.
- In RUN, assert load_req together with halt -> HDR next cycle; core_rst=1, clk_en=0, cycle_cnt=0, err=0. Then apply rst mid-BODY -> all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/tis_pkg.sv
// Shared definitions for the TIS grid loader: stream header layout, the NOP
// filler word and the controller state encoding.
package tis_pkg;

  // Header word layout
  localparam int unsigned HDR_BIT  = 15;  // 1 marks a header word
  localparam int unsigned END_BIT  = 14;  // 1 marks the END header
  localparam int unsigned CORE_MSB = 11;
  localparam int unsigned CORE_LSB = 8;
  localparam int unsigned LEN_MSB  = 3;
  localparam int unsigned LEN_LSB  = 0;

  // Written to slot 0 of a core whose frame declares zero instructions
  localparam logic [15:0] NOP_WORD = 16'h7FFF;

  typedef enum logic [2:0] {
    HDR,
    BODY,
    FILL,
    DRAIN,
    READY,
    RUN
  } state_e;

endpackage

// File: rtl/tis_grid_loader.sv
// Configuration and run controller for a grid of TIS cores.
// Decodes a framed word stream into program-store writes while holding the
// cores in reset, then sequences free-run, single-step and halt.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   in_valid/in_data/in_ready  16-bit word stream handshake
//   load_req                   abort execution and return to loading
//   start_run, step, halt      execution control
//   core_rst, clk_en           reset and execute enable fanned out to all cores
//   prog_we/core/addr/wdata    instruction write strobe and payload
//   plen_we/plen_wdata         program-length write strobe and payload
//   running, err, cycle_cnt    status: in RUN, sticky frame error, executed cycles
// All outputs are registered; strobes appear one cycle after their handshake.
module tis_grid_loader
  import tis_pkg::*;
#(
  parameter int unsigned NCORES     = 12,
  parameter int unsigned PROG_DEPTH = 15,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [15:0]      in_data,
  output logic             in_ready,
  input  logic             load_req,
  input  logic             start_run,
  input  logic             step,
  input  logic             halt,
  output logic             core_rst,
  output logic             clk_en,
  output logic             prog_we,
  output logic [3:0]       prog_core,
  output logic [3:0]       prog_addr,
  output logic [15:0]      prog_wdata,
  output logic             plen_we,
  output logic [3:0]       plen_wdata,
  output logic             running,
  output logic             err,
  output logic [CNT_W-1:0] cycle_cnt
);

  state_e state_q, state_d;

  logic             in_ready_q, in_ready_d;
  logic             core_rst_q, core_rst_d;
  logic             clk_en_q, clk_en_d;
  logic             running_q, running_d;
  logic             err_q, err_d;
  logic             prog_we_q, prog_we_d;
  logic [3:0]       prog_core_q, prog_core_d;
  logic [3:0]       prog_addr_q, prog_addr_d;
  logic [15:0]      prog_wdata_q, prog_wdata_d;
  logic             plen_we_q, plen_we_d;
  logic [3:0]       plen_wdata_q, plen_wdata_d;
  logic [3:0]       idx_q, idx_d;
  logic [3:0]       len_q, len_d;
  logic             step_prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       accept;
  logic       step_rise;
  logic       step_fire;
  logic [3:0] hdr_core;
  logic [3:0] hdr_len;

  // in_ready_q always mirrors the current state, so this is the true handshake
  assign accept    = in_valid & in_ready_q;
  assign step_rise = step & ~step_prev_q;
  assign hdr_core  = in_data[CORE_MSB:CORE_LSB];
  assign hdr_len   = in_data[LEN_MSB:LEN_LSB];

  always_comb begin
    state_d      = state_q;
    err_d        = err_q;
    prog_we_d    = 1'b0;
    plen_we_d    = 1'b0;
    prog_core_d  = prog_core_q;
    prog_addr_d  = prog_addr_q;
    prog_wdata_d = prog_wdata_q;
    plen_wdata_d = plen_wdata_q;
    idx_d        = idx_q;
    len_d        = len_q;
    step_fire    = 1'b0;
    cnt_d        = cnt_q;

    if (clk_en_q && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      HDR: begin
        if (accept) begin
          if (!in_data[HDR_BIT]) begin
            state_d = DRAIN;
            err_d   = 1'b1;
          end else if (in_data[END_BIT]) begin
            state_d = READY;
          end else if ((32'(hdr_core) >= NCORES) || (32'(hdr_len) > PROG_DEPTH)) begin
            state_d = DRAIN;
            err_d   = 1'b1;
          end else if (hdr_len == 4'd0) begin
            // Empty program becomes a single NOP so the core still has something to run
            state_d      = FILL;
            prog_core_d  = hdr_core;
            plen_we_d    = 1'b1;
            plen_wdata_d = 4'd1;
            prog_we_d    = 1'b1;
            prog_addr_d  = 4'd0;
            prog_wdata_d = NOP_WORD;
          end else begin
            state_d      = BODY;
            prog_core_d  = hdr_core;
            plen_we_d    = 1'b1;
            plen_wdata_d = hdr_len;
            idx_d        = 4'd0;
            len_d        = hdr_len;
          end
        end
      end
      FILL: state_d = HDR;
      BODY: begin
        if (accept) begin
          prog_we_d    = 1'b1;
          prog_addr_d  = idx_q;
          prog_wdata_d = in_data;
          idx_d        = idx_q + 4'd1;
          if (idx_q == len_q - 4'd1) begin
            state_d = HDR;
          end
        end
      end
      DRAIN: begin
        if (accept && in_data[HDR_BIT] && in_data[END_BIT]) begin
          state_d = READY;
        end
      end
      READY: begin
        if (load_req) begin
          state_d = HDR;
          err_d   = 1'b0;
          cnt_d   = '0;
        end else if (halt) begin
          state_d = READY;  // halt outranks start_run/step even when idle
        end else if (start_run && !err_q) begin
          state_d = RUN;
        end else if (step_rise && !err_q) begin
          step_fire = 1'b1;
        end
      end
      RUN: begin
        if (load_req) begin
          state_d = HDR;
          err_d   = 1'b0;
          cnt_d   = '0;
        end else if (halt) begin
          state_d = READY;
        end
      end
      default: state_d = HDR;
    endcase

    // Level outputs are registered from the next state so they align with it
    in_ready_d  = (state_d == HDR) || (state_d == BODY) || (state_d == DRAIN);
    core_rst_d  = (state_d != READY) && (state_d != RUN);
    running_d   = (state_d == RUN);
    clk_en_d    = (state_d == RUN) || step_fire;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= HDR;
      in_ready_q   <= 1'b1;
      core_rst_q   <= 1'b1;
      clk_en_q     <= 1'b0;
      running_q    <= 1'b0;
      err_q        <= 1'b0;
      prog_we_q    <= 1'b0;
      prog_core_q  <= 4'd0;
      prog_addr_q  <= 4'd0;
      prog_wdata_q <= 16'd0;
      plen_we_q    <= 1'b0;
      plen_wdata_q <= 4'd0;
      idx_q        <= 4'd0;
      len_q        <= 4'd0;
      step_prev_q  <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      core_rst_q   <= core_rst_d;
      clk_en_q     <= clk_en_d;
      running_q    <= running_d;
      err_q        <= err_d;
      prog_we_q    <= prog_we_d;
      prog_core_q  <= prog_core_d;
      prog_addr_q  <= prog_addr_d;
      prog_wdata_q <= prog_wdata_d;
      plen_we_q    <= plen_we_d;
      plen_wdata_q <= plen_wdata_d;
      idx_q        <= idx_d;
      len_q        <= len_d;
      step_prev_q  <= step;
      cnt_q        <= cnt_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign core_rst   = core_rst_q;
  assign clk_en     = clk_en_q;
  assign running    = running_q;
  assign err        = err_q;
  assign prog_we    = prog_we_q;
  assign prog_core  = prog_core_q;
  assign prog_addr  = prog_addr_q;
  assign prog_wdata = prog_wdata_q;
  assign plen_we    = plen_we_q;
  assign plen_wdata = plen_wdata_q;
  assign cycle_cnt  = cnt_q;

endmodule

// File: tb/tb_tis_grid_loader.sv
// Directed bench for tis_grid_loader: loading, empty-frame fill, error drain,
// single-step, run/halt priority, load_req abort and mid-frame reset.
module tb_tis_grid_loader;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        load_req;
  logic        start_run;
  logic        step;
  logic        halt;
  logic        core_rst;
  logic        clk_en;
  logic        prog_we;
  logic [3:0]  prog_core;
  logic [3:0]  prog_addr;
  logic [15:0] prog_wdata;
  logic        plen_we;
  logic [3:0]  plen_wdata;
  logic        running;
  logic        err;
  logic [31:0] cycle_cnt;

  int n_tests;
  int n_fail;

  tis_grid_loader #(
    .NCORES    (12),
    .PROG_DEPTH(15),
    .CNT_W     (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .load_req  (load_req),
    .start_run (start_run),
    .step      (step),
    .halt      (halt),
    .core_rst  (core_rst),
    .clk_en    (clk_en),
    .prog_we   (prog_we),
    .prog_core (prog_core),
    .prog_addr (prog_addr),
    .prog_wdata(prog_wdata),
    .plen_we   (plen_we),
    .plen_wdata(plen_wdata),
    .running   (running),
    .err       (err),
    .cycle_cnt (cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One word presented for exactly one edge; caller knows in_ready is high
  task automatic send(input logic [15:0] w);
    in_valid = 1'b1;
    in_data  = w;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_core_rst"}, 32'(core_rst), 32'd1);
    check_eq({tag, "_clk_en"}, 32'(clk_en), 32'd0);
    check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check_eq({tag, "_prog_we"}, 32'(prog_we), 32'd0);
    check_eq({tag, "_plen_we"}, 32'(plen_we), 32'd0);
    check_eq({tag, "_err"}, 32'(err), 32'd0);
    check_eq({tag, "_cnt"}, cycle_cnt, 32'd0);
    check_eq({tag, "_running"}, 32'(running), 32'd0);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 16'd0;
    load_req  = 1'b0;
    start_run = 1'b0;
    step      = 1'b0;
    halt      = 1'b0;
    tick();
    tick();
    check_reset_vals("rst");
    rst = 1'b0;

    // Core 2, three instructions
    send(16'h8203);
    check_eq("hdr_plen_we", 32'(plen_we), 32'd1);
    check_eq("hdr_plen", 32'(plen_wdata), 32'd3);
    check_eq("hdr_core", 32'(prog_core), 32'd2);
    check_eq("hdr_prog_we", 32'(prog_we), 32'd0);
    send(16'h0802);
    check_eq("w0_we", 32'(prog_we), 32'd1);
    check_eq("w0_addr", 32'(prog_addr), 32'd0);
    check_eq("w0_data", 32'(prog_wdata), 32'h0802);
    check_eq("w0_plen_we", 32'(plen_we), 32'd0);
    send(16'h4801);
    check_eq("w1_addr", 32'(prog_addr), 32'd1);
    check_eq("w1_data", 32'(prog_wdata), 32'h4801);
    send(16'h7FFF);
    check_eq("w2_we", 32'(prog_we), 32'd1);
    check_eq("w2_addr", 32'(prog_addr), 32'd2);
    check_eq("w2_data", 32'(prog_wdata), 32'h7FFF);
    check_eq("w2_core_rst", 32'(core_rst), 32'd1);
    send(16'hC000);
    check_eq("end_core_rst", 32'(core_rst), 32'd0);
    check_eq("end_in_ready", 32'(in_ready), 32'd0);
    check_eq("end_prog_we", 32'(prog_we), 32'd0);
    check_eq("end_clk_en", 32'(clk_en), 32'd0);

    // Core 5 with zero length: one FILL cycle writing a NOP
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    check_eq("reload_core_rst", 32'(core_rst), 32'd1);
    check_eq("reload_in_ready", 32'(in_ready), 32'd1);
    send(16'h8500);
    check_eq("fill_in_ready", 32'(in_ready), 32'd0);
    check_eq("fill_plen_we", 32'(plen_we), 32'd1);
    check_eq("fill_plen", 32'(plen_wdata), 32'd1);
    check_eq("fill_core", 32'(prog_core), 32'd5);
    check_eq("fill_we", 32'(prog_we), 32'd1);
    check_eq("fill_addr", 32'(prog_addr), 32'd0);
    check_eq("fill_data", 32'(prog_wdata), 32'h7FFF);
    tick();
    check_eq("post_fill_in_ready", 32'(in_ready), 32'd1);
    check_eq("post_fill_we", 32'(prog_we), 32'd0);
    send(16'hC000);
    check_eq("fill_end_core_rst", 32'(core_rst), 32'd0);

    // Core 13 is out of range: drain to END with err set, no strobes
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    send(16'h8D02);
    check_eq("bad_err", 32'(err), 32'd1);
    check_eq("bad_plen_we", 32'(plen_we), 32'd0);
    check_eq("bad_in_ready", 32'(in_ready), 32'd1);
    send(16'h1234);
    check_eq("drain_we0", 32'(prog_we), 32'd0);
    send(16'h8D02);
    check_eq("drain_we1", 32'(prog_we), 32'd0);
    check_eq("drain_plen_we", 32'(plen_we), 32'd0);
    check_eq("drain_core_rst", 32'(core_rst), 32'd1);
    send(16'hC000);
    check_eq("drain_end_core_rst", 32'(core_rst), 32'd0);
    check_eq("drain_end_err", 32'(err), 32'd1);
    start_run = 1'b1;
    tick();
    start_run = 1'b0;
    check_eq("err_run_running", 32'(running), 32'd0);
    check_eq("err_run_clk_en", 32'(clk_en), 32'd0);
    step = 1'b1;
    tick();
    step = 1'b0;
    check_eq("err_step_clk_en", 32'(clk_en), 32'd0);
    tick();
    check_eq("err_cnt", cycle_cnt, 32'd0);

    // Clean READY, then three held step pulses
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    check_eq("clr_err", 32'(err), 32'd0);
    send(16'hC000);
    for (int k = 0; k < 3; k++) begin
      step = 1'b1;
      tick();
      check_eq($sformatf("step%0d_pulse", k), 32'(clk_en), 32'd1);
      tick();
      check_eq($sformatf("step%0d_held", k), 32'(clk_en), 32'd0);
      step = 1'b0;
      tick();
      check_eq($sformatf("step%0d_low", k), 32'(clk_en), 32'd0);
      tick();
    end
    check_eq("step_cnt", cycle_cnt, 32'd3);
    check_eq("step_running", 32'(running), 32'd0);

    // Free-run for 10 cycles from a cleared counter; halt beats start_run
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    check_eq("run_pre_cnt", cycle_cnt, 32'd0);
    send(16'hC000);
    start_run = 1'b1;
    tick();
    start_run = 1'b0;
    check_eq("run_running", 32'(running), 32'd1);
    check_eq("run_clk_en", 32'(clk_en), 32'd1);
    repeat (9) tick();
    halt      = 1'b1;
    start_run = 1'b1;
    tick();
    halt      = 1'b0;
    start_run = 1'b0;
    check_eq("halt_clk_en", 32'(clk_en), 32'd0);
    check_eq("halt_running", 32'(running), 32'd0);
    check_eq("halt_cnt", cycle_cnt, 32'd10);
    check_eq("halt_core_rst", 32'(core_rst), 32'd0);
    tick();
    check_eq("halt_stays", 32'(running), 32'd0);
    check_eq("halt_cnt_hold", cycle_cnt, 32'd10);

    // load_req beats halt while running
    start_run = 1'b1;
    tick();
    start_run = 1'b0;
    repeat (3) tick();
    load_req = 1'b1;
    halt     = 1'b1;
    tick();
    load_req = 1'b0;
    halt     = 1'b0;
    check_eq("ld_core_rst", 32'(core_rst), 32'd1);
    check_eq("ld_clk_en", 32'(clk_en), 32'd0);
    check_eq("ld_cnt", cycle_cnt, 32'd0);
    check_eq("ld_err", 32'(err), 32'd0);
    check_eq("ld_running", 32'(running), 32'd0);
    check_eq("ld_in_ready", 32'(in_ready), 32'd1);

    // Reset in the middle of a frame
    send(16'h8104);
    check_eq("mid_plen", 32'(plen_wdata), 32'd4);
    check_eq("mid_core", 32'(prog_core), 32'd1);
    send(16'h1111);
    check_eq("mid_we", 32'(prog_we), 32'd1);
    in_valid = 1'b1;
    in_data  = 16'h2222;
    rst      = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    check_reset_vals("midrst");
    // Back in HDR, so a word without bit15 is a frame error
    send(16'h0005);
    check_eq("post_rst_err", 32'(err), 32'd1);
    check_eq("post_rst_we", 32'(prog_we), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
